vid_obj_fetch: RTL and testbench

Clip-side reader of the 32-entry video object memory. On a start command it walks addresses 0..num_objs-1 using the memory's clip read port (clip_addr/clip_rd_en, registered data one cycle later). It unpacks each 144-bit object into vertex, colour and type fields, skips empty slots, and hands each live object to the clipping engine over a valid/ready handshake. It signals done when the sweep completes.

---
 rtl/vid_obj_fetch_if.sv | 34 +++
 rtl/vid_obj_fetch.sv | 145 ++++++++++++++
 tb/tb_vid_obj_fetch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_obj_fetch_if.sv
// Clip-side memory read port plus the object handshake to the clipping engine.
interface vid_obj_fetch_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OBJ_W  = 144
);
  logic [ADDR_W-1:0] clip_addr;
  logic              clip_rd_en;
  logic [OBJ_W-1:0]  clip_obj_in;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_idx;
  logic [15:0]       out_x0, out_y0, out_x1, out_y1;
  logic [15:0]       out_x2, out_y2, out_x3, out_y3;
  logic [11:0]       out_color;
  logic [3:0]        out_type;

  modport master (
    output clip_addr, clip_rd_en,
    input  clip_obj_in,
    output out_valid,
    input  out_ready,
    output out_idx, out_x0, out_y0, out_x1, out_y1,
           out_x2, out_y2, out_x3, out_y3, out_color, out_type
  );

  modport slave (
    input  clip_addr, clip_rd_en,
    output clip_obj_in,
    input  out_valid,
    output out_ready,
    input  out_idx, out_x0, out_y0, out_x1, out_y1,
           out_x2, out_y2, out_x3, out_y3, out_color, out_type
  );
endinterface

// File: rtl/vid_obj_fetch.sv
// Sweeps the video object memory, skips empty slots and presents each live
// object to the clipping engine over valid/ready.
module vid_obj_fetch #(
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned OBJ_W       = 144
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [5:0]             num_objs,
  vid_obj_fetch_if.master        bus,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] MAX_OBJS = CNT_W'(NUM_ENTRIES);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_HOLD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OBJ_W-1:0]  obj_q, obj_d;
  logic [IDX_W-1:0]  oidx_q, oidx_d;
  logic              rd_en_q, rd_en_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              slot_empty_c;

  assign slot_empty_c = (bus.clip_obj_in[143:140] == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      obj_q   <= '0;
      oidx_q  <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      obj_q   <= obj_d;
      oidx_q  <= oidx_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    addr_d  = addr_q;
    obj_d   = obj_q;
    oidx_d  = oidx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          idx_d   = '0;
          last_d  = (num_objs >= MAX_OBJS) ? IDX_W'(NUM_ENTRIES - 1)
                                           : IDX_W'(num_objs - CNT_W'(1));
          state_d = (num_objs == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (slot_empty_c) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD;
          end
        end else begin
          obj_d   = bus.clip_obj_in;
          oidx_d  = idx_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort cancels the sweep outright; presented fields keep their values.
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      obj_d   = obj_q;
      oidx_d  = oidx_q;
    end

    // Strobes and flags are decoded from the next state so they stay registered.
    rd_en_d = (state_d == S_RD);
    valid_d = (state_d == S_HOLD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    if (state_d == S_RD) begin
      addr_d = ADDR_W'(idx_d);
    end
  end

  assign bus.clip_addr  = addr_q;
  assign bus.clip_rd_en = rd_en_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = oidx_q;
  assign bus.out_x0     = obj_q[15:0];
  assign bus.out_y0     = obj_q[31:16];
  assign bus.out_x1     = obj_q[47:32];
  assign bus.out_y1     = obj_q[63:48];
  assign bus.out_x2     = obj_q[79:64];
  assign bus.out_y2     = obj_q[95:80];
  assign bus.out_x3     = obj_q[111:96];
  assign bus.out_y3     = obj_q[127:112];
  assign bus.out_color  = obj_q[139:128];
  assign bus.out_type   = obj_q[143:140];
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_vid_obj_fetch.sv
// Bench for vid_obj_fetch: sweep table plus random sweeps scored against a
// slot-list model, and hand sequences for backpressure, abort and reset.
module tb_vid_obj_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] num_objs = '0;
  logic       busy, done;

  vid_obj_fetch_if bus ();

  vid_obj_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .num_objs (num_objs),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Memory model with a registered read port.
  logic [143:0] mem [32];
  logic [143:0] rdata = '0;
  always @(posedge clk) if (bus.clip_rd_en) rdata <= mem[bus.clip_addr];
  assign bus.clip_obj_in = rdata;

  logic [148:0] got;
  assign got = {bus.out_idx, bus.out_type, bus.out_color, bus.out_y3, bus.out_x3,
                bus.out_y2, bus.out_x2, bus.out_y1, bus.out_x1, bus.out_y0, bus.out_x0};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  int  cyc = 0;
  bit  mon_en = 0;
  int  exp_q[$];
  int  mon_reads, mon_done, mon_hs;
  int  start_cyc, first_valid_cyc, done_cyc, last_rd_cyc, last_hs_cyc;
  bit  prev_hold;
  logic [148:0] prev_got;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) chk("done_excl_valid", 160'(bus.out_valid), 160'(0));
    if (mon_en) begin
      if (start && !busy && start_cyc < 0) start_cyc = cyc;
      if (bus.clip_rd_en) begin
        chk("rd_addr", 160'(bus.clip_addr), 160'(mon_reads));
        mon_reads++;
        last_rd_cyc = cyc;
      end
      if (done) begin
        mon_done++;
        done_cyc = cyc;
      end
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_hold) chk("hold_stable", 160'(got), 160'(prev_got));
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_obj", 160'(1), 160'(0));
          end else begin
            int s;
            logic [148:0] e;
            s = exp_q.pop_front();
            e = {5'(s), mem[s]};
            chk("obj", 160'(got), 160'(e));
          end
          mon_hs++;
          last_hs_cyc = cyc;
        end
      end else if (prev_hold) begin
        chk("hold_dropped", 160'(0), 160'(1));
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_got  = got;
    end
  end

  // Fill memory: live slots get a random nonzero type, empty slots type 0.
  task automatic fill_mem(input logic [31:0] mask);
    for (int s = 0; s < 32; s++) begin
      logic [143:0] w;
      w = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
      w[143:140] = mask[s] ? 4'($urandom_range(15, 1)) : 4'd0;
      mem[s] = w;
    end
  endtask

  task automatic run_sweep(input int n, input logic [31:0] mask, input int rdy,
                           input bit restart, input int exp_reads, input int exp_objs);
    int nn, eo;
    bit got_done;
    fill_mem(mask);
    nn = (n > 32) ? 32 : n;
    exp_q.delete();
    for (int s = 0; s < nn; s++) if (mask[s]) exp_q.push_back(s);
    eo = (exp_objs < 0) ? exp_q.size() : exp_objs;
    mon_reads = 0; mon_done = 0; mon_hs = 0; prev_hold = 0;
    start_cyc = -1; first_valid_cyc = -1; done_cyc = -1; last_rd_cyc = -1; last_hs_cyc = -1;
    mon_en = 1;
    @(posedge clk); #1;
    start = 1'b1;
    num_objs = 6'(n);
    bus.out_ready = ($urandom_range(99) < rdy);
    got_done = 0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      @(posedge clk); #1;
      if (restart && c == 4) begin
        start = 1'b1;
        num_objs = 6'd20;
      end else begin
        start = 1'b0;
      end
      bus.out_ready = ($urandom_range(99) < rdy);
      got_done = (mon_done > 0);
    end
    if (!got_done) chk("sweep_timeout", 160'(0), 160'(1));
    repeat (3) @(posedge clk);
    #1;
    mon_en = 0;
    chk("reads", 160'(mon_reads), 160'(exp_reads));
    chk("objs", 160'(mon_hs), 160'(eo));
    chk("model_left", 160'(exp_q.size()), 160'(0));
    chk("done_count", 160'(mon_done), 160'(1));
    chk("idle_busy", 160'(busy), 160'(0));
    if (n == 0) chk("done_lat_empty", 160'(done_cyc - start_cyc), 160'(1));
    else if (mask[nn-1]) chk("done_after_hs", 160'(done_cyc - last_hs_cyc), 160'(1));
    else chk("done_after_cap", 160'(done_cyc - last_rd_cyc), 160'(2));
    if (nn > 0 && mask[0]) chk("first_valid_lat", 160'(first_valid_cyc - start_cyc), 160'(3));
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      seen = done;
    end
    if (!seen) chk(nm, 160'(0), 160'(1));
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_objs = 6'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    int         n;
    logic [31:0] mask;
    int         rdy;
    bit         restart;
    int         exp_reads;
    int         exp_objs;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit seen;
    tbl[0] = '{4,  32'h0000000F, 100, 1'b0, 4,  4};
    tbl[1] = '{5,  32'h00000009, 100, 1'b0, 5,  2};
    tbl[2] = '{0,  32'hFFFFFFFF, 100, 1'b0, 0,  0};
    tbl[3] = '{40, 32'hFFFFFFFF, 100, 1'b0, 32, 32};
    tbl[4] = '{32, 32'h80000001, 60,  1'b0, 32, 2};
    tbl[5] = '{1,  32'h00000000, 100, 1'b0, 1,  0};
    tbl[6] = '{33, 32'h0000FF00, 40,  1'b0, 32, 8};
    tbl[7] = '{7,  32'h00000055, 50,  1'b0, 7,  4};
    tbl[8] = '{3,  32'h00000007, 100, 1'b1, 3,  3};
    bus.out_ready = 1'b0;
    fill_mem(32'h0);

    #3;
    chk("reset_outputs", 160'({bus.clip_rd_en, bus.clip_addr, bus.out_valid, done, busy, got}), 160'(0));
    #9 rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_sweep(tbl[i].n, tbl[i].mask, tbl[i].rdy, tbl[i].restart, tbl[i].exp_reads, tbl[i].exp_objs);

    for (int i = 0; i < 6; i++) begin
      int n;
      n = $urandom_range(40);
      run_sweep(n, $urandom, $urandom_range(100, 20), 1'b0, (n > 32) ? 32 : n, -1);
    end

    // Backpressure: single object held for 10 cycles.
    fill_mem(32'h1);
    mem[0][127:112] = 16'hBEEF;
    bus.out_ready = 1'b0;
    pulse_start(1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      seen = bus.out_valid;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("bp_valid_seen", 160'(seen), 160'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 160'(bus.out_valid), 160'(1));
      chk("bp_y3", 160'(bus.out_y3), 160'(16'hBEEF));
      chk("bp_no_rd", 160'(bus.clip_rd_en), 160'(0));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("bp_done_timeout");

    // Abort while holding the object from slot 2.
    fill_mem(32'hFF);
    bus.out_ready = 1'b1;
    pulse_start(8);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      seen = bus.out_valid && (bus.out_idx == 5'd2);
      bus.out_ready = !seen;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("abort_reach_idx2", 160'(seen), 160'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", 160'(bus.out_valid), 160'(0));
    chk("abort_busy", 160'(busy), 160'(0));
    chk("abort_idx_hold", 160'(bus.out_idx), 160'(2));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", 160'(done), 160'(0));
    end
    bus.out_ready = 1'b1;
    run_sweep(1, 32'h1, 100, 1'b0, 1, 1);

    // Asynchronous reset mid-sweep at slot 7.
    fill_mem(32'hFFFFFFFF);
    bus.out_ready = 1'b1;
    pulse_start(32);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      seen = bus.clip_rd_en && (bus.clip_addr == 5'd7);
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("rst_reach_idx7", 160'(seen), 160'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 160'({bus.clip_rd_en, bus.clip_addr, bus.out_valid, done, busy, got}), 160'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_sweep(2, 32'h3, 100, 1'b0, 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
